// File: rtl/draw_result_banner_if.sv
// rtl/draw_result_banner_if.sv - VGA timing and colour bundle passed between draw-chain stages
interface vga_if;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_result_banner.sv
// rtl/draw_result_banner.sv - animated WIN/LOSE/DRAW text overlay with 2-clk pixel pipeline
// Glyphs come from an internal 8x8 ROM scaled by 2^SCALE_LOG2; reveal, blink, then hold.
module draw_result_banner #(
   parameter int          XPOS          = 600,
   parameter int          YPOS          = 334,
   parameter int          SCALE_LOG2    = 2,
   parameter logic [11:0] FG_COLOR      = 12'hfa5,
   parameter bit          BG_EN         = 1'b1,
   parameter logic [11:0] BG_COLOR      = 12'h000,
   parameter logic [2:0]  ST_WIN        = 3'b011,
   parameter logic [2:0]  ST_LOSE       = 3'b100,
   parameter logic [2:0]  ST_DRAW       = 3'b101,
   parameter int          REVEAL_FRAMES = 8,
   parameter int          BLINK_FRAMES  = 15,
   parameter int          BLINK_TOGGLES = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] state,
   vga_if.in          vga_in,
   vga_if.out         vga_out,
   output logic       anim_done
);
   localparam int CW   = 8 << SCALE_LOG2;
   localparam int CL2  = 3 + SCALE_LOG2;
   localparam int FMAX = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
   localparam int FW   = $clog2(FMAX + 1);
   localparam int TW   = $clog2(BLINK_TOGGLES + 2);
   localparam int BX0  = (XPOS >= CW) ? XPOS - CW : 0;
   localparam int BY0  = (YPOS >= CW) ? YPOS - CW : 0;
   localparam int BY1  = YPOS + 2 * CW;

   typedef enum logic [1:0] {IDLE, REVEAL, BLINK, HOLD} fsm_t;

   fsm_t          fsm;
   logic [2:0]    msg_code;
   logic [2:0]    shown;
   logic [FW-1:0] fcnt;
   logic [TW-1:0] tcnt;
   logic          vis;
   logic          vblnk_q;
   logic          tick;
   logic          is_result;
   logic          restart;
   logic [2:0]    len;

   assign tick      = vga_in.vblnk & ~vblnk_q;
   assign is_result = (state == ST_WIN) || (state == ST_LOSE) || (state == ST_DRAW);
   assign restart   = is_result && ((fsm == IDLE) || (state != msg_code));
   assign len       = (msg_code == ST_WIN) ? 3'd3 : 3'd4;

   // A code change always beats a coincident frame tick, so counters restart cleanly.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm       <= IDLE;
         msg_code  <= 3'd0;
         shown     <= 3'd0;
         fcnt      <= '0;
         tcnt      <= '0;
         vis       <= 1'b0;
         vblnk_q   <= 1'b0;
         anim_done <= 1'b0;
      end else begin
         vblnk_q <= vga_in.vblnk;
         if (restart) begin
            msg_code  <= state;
            shown     <= 3'd1;
            fcnt      <= '0;
            tcnt      <= '0;
            vis       <= 1'b1;
            fsm       <= REVEAL;
            anim_done <= 1'b0;
         end else if (!is_result) begin
            fsm       <= IDLE;
            fcnt      <= '0;
            tcnt      <= '0;
            anim_done <= 1'b0;
         end else if (tick) begin
            case (fsm)
               REVEAL: begin
                  if (fcnt == FW'(REVEAL_FRAMES - 1)) begin
                     fcnt  <= '0;
                     shown <= shown + 3'd1;
                     if (shown + 3'd1 == len) begin
                        tcnt <= '0;
                        if (BLINK_TOGGLES == 0) begin
                           fsm       <= HOLD;
                           vis       <= 1'b1;
                           anim_done <= 1'b1;
                        end else begin
                           fsm <= BLINK;
                        end
                     end
                  end else begin
                     fcnt <= fcnt + FW'(1);
                  end
               end
               BLINK: begin
                  if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                     fcnt <= '0;
                     vis  <= ~vis;
                     tcnt <= tcnt + TW'(1);
                     if (tcnt + TW'(1) == TW'(BLINK_TOGGLES)) begin
                        fsm       <= HOLD;
                        vis       <= 1'b1;
                        anim_done <= 1'b1;
                     end
                  end else begin
                     fcnt <= fcnt + FW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   function automatic logic [3:0] letter_of(input logic [2:0] code, input logic [1:0] idx);
      logic [15:0] word;
      if (code == ST_WIN)       word = {4'd0, 4'd1, 4'd2, 4'd0};
      else if (code == ST_LOSE) word = {4'd3, 4'd4, 4'd5, 4'd6};
      else                      word = {4'd7, 4'd8, 4'd9, 4'd0};
      case (idx)
         2'd0:    return word[15:12];
         2'd1:    return word[11:8];
         2'd2:    return word[7:4];
         default: return word[3:0];
      endcase
   endfunction

   // Letters W I N L O S E D R A; top row in the MS byte, column 7 and row 7 left blank.
   function automatic logic [7:0] glyph_row(input logic [3:0] l, input logic [2:0] r);
      logic [63:0] g;
      case (l)
         4'd0:    g = 64'h8282_8292_AAC6_8200;
         4'd1:    g = 64'h7C10_1010_1010_7C00;
         4'd2:    g = 64'h82C2_A292_8A86_8200;
         4'd3:    g = 64'h8080_8080_8080_FE00;
         4'd4:    g = 64'h7C82_8282_8282_7C00;
         4'd5:    g = 64'h7C82_807C_0282_7C00;
         4'd6:    g = 64'hFE80_80FC_8080_FE00;
         4'd7:    g = 64'hF884_8282_8284_F800;
         4'd8:    g = 64'hFC82_82FC_8884_8200;
         4'd9:    g = 64'h3844_8282_FE82_8200;
         default: g = 64'h0;
      endcase
      return g[8 * (7 - int'(r)) +: 8];
   endfunction

   logic [11:0] rx, ry, box_w;
   logic [13:0] bx1;
   logic        in_box, in_bg;

   always_comb begin
      rx     = {1'b0, vga_in.hcount} - 12'(XPOS);
      ry     = {1'b0, vga_in.vcount} - 12'(YPOS);
      box_w  = {9'd0, len} << CL2;
      in_box = ({1'b0, vga_in.hcount} >= 12'(XPOS)) && ({1'b0, vga_in.vcount} >= 12'(YPOS))
               && (rx < box_w) && (ry < 12'(CW));
      bx1    = 14'(XPOS + CW) + ({11'd0, len} << CL2);
      in_bg  = ({3'd0, vga_in.hcount} >= 14'(BX0)) && ({3'd0, vga_in.hcount} < bx1)
               && ({3'd0, vga_in.vcount} >= 14'(BY0)) && ({3'd0, vga_in.vcount} < 14'(BY1));
   end

   logic [10:0] s1_hcount, s1_vcount;
   logic        s1_hsync, s1_vsync, s1_hblnk, s1_vblnk;
   logic [11:0] s1_rgb;
   logic        s1_glyph_on, s1_bg_on;
   logic [3:0]  s1_letter;
   logic [2:0]  s1_row, s1_col;
   logic [7:0]  s2_bits;

   assign s2_bits = glyph_row(s1_letter, s1_row);

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_hcount   <= '0;
         s1_vcount   <= '0;
         s1_hsync    <= 1'b0;
         s1_vsync    <= 1'b0;
         s1_hblnk    <= 1'b0;
         s1_vblnk    <= 1'b0;
         s1_rgb      <= '0;
         s1_glyph_on <= 1'b0;
         s1_bg_on    <= 1'b0;
         s1_letter   <= '0;
         s1_row      <= '0;
         s1_col      <= '0;
         vga_out.hcount <= '0;
         vga_out.vcount <= '0;
         vga_out.hsync  <= 1'b0;
         vga_out.vsync  <= 1'b0;
         vga_out.hblnk  <= 1'b0;
         vga_out.vblnk  <= 1'b0;
         vga_out.rgb    <= '0;
      end else begin
         s1_hcount   <= vga_in.hcount;
         s1_vcount   <= vga_in.vcount;
         s1_hsync    <= vga_in.hsync;
         s1_vsync    <= vga_in.vsync;
         s1_hblnk    <= vga_in.hblnk;
         s1_vblnk    <= vga_in.vblnk;
         s1_rgb      <= vga_in.rgb;
         s1_glyph_on <= in_box && vis && (fsm != IDLE) && ({1'b0, rx[CL2 +: 2]} < shown);
         s1_bg_on    <= BG_EN && in_bg && (fsm != IDLE);
         s1_letter   <= letter_of(msg_code, rx[CL2 +: 2]);
         s1_row      <= ry[SCALE_LOG2 +: 3];
         s1_col      <= rx[SCALE_LOG2 +: 3];

         vga_out.hcount <= s1_hcount;
         vga_out.vcount <= s1_vcount;
         vga_out.hsync  <= s1_hsync;
         vga_out.vsync  <= s1_vsync;
         vga_out.hblnk  <= s1_hblnk;
         vga_out.vblnk  <= s1_vblnk;
         if (s1_hblnk || s1_vblnk)
            vga_out.rgb <= s1_rgb;
         else if (s1_glyph_on && s2_bits[3'd7 - s1_col])
            vga_out.rgb <= FG_COLOR;
         else if (s1_bg_on)
            vga_out.rgb <= BG_COLOR;
         else
            vga_out.rgb <= s1_rgb;
      end
   end
endmodule

// File: tb/tb_draw_result_banner.sv
// tb/tb_draw_result_banner.sv - directed bench for draw_result_banner
module tb_draw_result_banner;
   localparam logic [11:0] IN_RGB = 12'h5a5;
   localparam logic [11:0] FG     = 12'hfa5;
   localparam logic [11:0] BG     = 12'h000;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] state;
   logic       anim_done;
   int         n_cmp = 0;
   int         n_bad = 0;

   vga_if vin();
   vga_if vout();

   draw_result_banner #(
      .XPOS(600), .YPOS(334), .SCALE_LOG2(2), .FG_COLOR(12'hfa5), .BG_EN(1'b1),
      .BG_COLOR(12'h000), .ST_WIN(3'b011), .ST_LOSE(3'b100), .ST_DRAW(3'b101),
      .REVEAL_FRAMES(2), .BLINK_FRAMES(3), .BLINK_TOGGLES(4)
   ) dut (
      .clk(clk), .rst(rst), .state(state), .vga_in(vin), .vga_out(vout), .anim_done(anim_done)
   );

   always #5 clk = ~clk;

   task automatic probe(input int h, input int v, input logic hb, output logic [11:0] rgb_o);
      vin.hcount = 11'(h);
      vin.vcount = 11'(v);
      vin.hblnk  = hb;
      vin.vblnk  = 1'b0;
      vin.rgb    = IN_RGB;
      @(posedge clk); @(posedge clk); #1;
      rgb_o = vout.rgb;
   endtask

   task automatic frame_tick();
      vin.vblnk = 1'b1;
      @(posedge clk); #1;
      vin.vblnk = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; state = 3'b011;
      vin.hcount = 11'd601; vin.vcount = 11'd335; vin.hsync = 1'b1; vin.vsync = 1'b1;
      vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = IN_RGB;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb} !== 39'd0) begin
         n_bad++;
         $display("FAIL reset_vga got %h/%h/%h exp all 0", vout.hcount, vout.vcount, vout.rgb);
      end
      n_cmp++;
      if (anim_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", anim_done); end
      rst = 1'b1; state = 3'b000;
   endtask

   task automatic test_latency();
      logic [38:0] exp_v;
      for (int i = 0; i < 8; i++) begin
         if (i >= 2) begin
            int j;
            j = i - 2;
            exp_v = {11'(10 + j), 11'(20 + j), j[0], j[1], j[2], 1'b0, 12'(12'h111 * j)};
            n_cmp++;
            if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb} !== exp_v) begin
               n_bad++;
               $display("FAIL latency_%0d got %h exp %h", i,
                        {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb}, exp_v);
            end
         end
         vin.hcount = 11'(10 + i); vin.vcount = 11'(20 + i);
         vin.hsync = i[0]; vin.vsync = i[1]; vin.hblnk = i[2]; vin.vblnk = 1'b0;
         vin.rgb = 12'(12'h111 * i);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_idle_pass();
      logic [11:0] r;
      probe(601, 335, 1'b0, r);
      n_cmp++;
      if (r !== IN_RGB) begin n_bad++; $display("FAIL idle_pass got %h exp %h", r, IN_RGB); end
   endtask

   task automatic test_reveal();
      logic [11:0] r;
      state = 3'b011;
      @(posedge clk); #1;
      probe(601, 335, 1'b0, r);
      n_cmp++; if (r !== FG) begin n_bad++; $display("FAIL reveal_w got %h exp %h", r, FG); end
      probe(637, 335, 1'b0, r);
      n_cmp++; if (r !== BG) begin n_bad++; $display("FAIL reveal_i_hidden got %h exp %h", r, BG); end
      probe(613, 335, 1'b0, r);
      n_cmp++; if (r !== BG) begin n_bad++; $display("FAIL reveal_w_gap got %h exp %h", r, BG); end
      probe(740, 335, 1'b0, r);
      n_cmp++; if (r !== IN_RGB) begin n_bad++; $display("FAIL win_bg_right got %h exp %h", r, IN_RGB); end
      probe(601, 301, 1'b0, r);
      n_cmp++; if (r !== IN_RGB) begin n_bad++; $display("FAIL bg_above got %h exp %h", r, IN_RGB); end
      probe(601, 302, 1'b0, r);
      n_cmp++; if (r !== BG) begin n_bad++; $display("FAIL bg_top got %h exp %h", r, BG); end
      probe(601, 335, 1'b1, r);
      n_cmp++; if (r !== IN_RGB) begin n_bad++; $display("FAIL hblnk_pass got %h exp %h", r, IN_RGB); end
      frame_tick();
      probe(637, 335, 1'b0, r);
      n_cmp++; if (r !== BG) begin n_bad++; $display("FAIL reveal_i_tick1 got %h exp %h", r, BG); end
      frame_tick();
      probe(637, 335, 1'b0, r);
      n_cmp++; if (r !== FG) begin n_bad++; $display("FAIL reveal_i_tick2 got %h exp %h", r, FG); end
      probe(665, 335, 1'b0, r);
      n_cmp++; if (r !== BG) begin n_bad++; $display("FAIL reveal_n_tick2 got %h exp %h", r, BG); end
      frame_tick();
      frame_tick();
      probe(665, 335, 1'b0, r);
      n_cmp++; if (r !== FG) begin n_bad++; $display("FAIL reveal_n_tick4 got %h exp %h", r, FG); end
   endtask

   task automatic test_blink();
      logic [11:0] r;
      logic [11:0] exp_rgb;
      logic        exp_done;
      for (int f = 1; f <= 13; f++) begin
         frame_tick();
         probe(601, 335, 1'b0, r);
         exp_rgb  = ((f >= 3 && f <= 5) || (f >= 9 && f <= 11)) ? BG : FG;
         exp_done = (f >= 12);
         n_cmp++;
         if (r !== exp_rgb) begin n_bad++; $display("FAIL blink_f%0d got %h exp %h", f, r, exp_rgb); end
         n_cmp++;
         if (anim_done !== exp_done) begin n_bad++; $display("FAIL done_f%0d got %b exp %b", f, anim_done, exp_done); end
      end
   endtask

   task automatic test_exit();
      logic [11:0] r;
      state = 3'b000;
      @(posedge clk); #1;
      probe(601, 335, 1'b0, r);
      n_cmp++; if (r !== IN_RGB) begin n_bad++; $display("FAIL exit_glyph got %h exp %h", r, IN_RGB); end
      probe(590, 335, 1'b0, r);
      n_cmp++; if (r !== IN_RGB) begin n_bad++; $display("FAIL exit_bg got %h exp %h", r, IN_RGB); end
      n_cmp++; if (anim_done !== 1'b0) begin n_bad++; $display("FAIL exit_done got %b exp 0", anim_done); end
   endtask

   task automatic test_switch();
      logic [11:0] r;
      state = 3'b011;
      @(posedge clk); #1;
      frame_tick();
      state = 3'b100; vin.vblnk = 1'b1;
      @(posedge clk); #1;
      vin.vblnk = 1'b0;
      @(posedge clk); #1;
      frame_tick();
      probe(601, 335, 1'b0, r);
      n_cmp++; if (r !== FG) begin n_bad++; $display("FAIL switch_l got %h exp %h", r, FG); end
      probe(637, 335, 1'b0, r);
      n_cmp++; if (r !== BG) begin n_bad++; $display("FAIL switch_o_hidden got %h exp %h", r, BG); end
      probe(697, 335, 1'b0, r);
      n_cmp++; if (r !== BG) begin n_bad++; $display("FAIL switch_char3 got %h exp %h", r, BG); end
      probe(740, 335, 1'b0, r);
      n_cmp++; if (r !== BG) begin n_bad++; $display("FAIL lose_bg_right got %h exp %h", r, BG); end
      n_cmp++; if (anim_done !== 1'b0) begin n_bad++; $display("FAIL switch_done got %b exp 0", anim_done); end
      frame_tick();
      probe(637, 335, 1'b0, r);
      n_cmp++; if (r !== FG) begin n_bad++; $display("FAIL switch_o_shown got %h exp %h", r, FG); end
   endtask

   task automatic test_abort();
      logic [11:0] r;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (vout.rgb !== 12'h000) begin n_bad++; $display("FAIL abort_rgb got %h exp 000", vout.rgb); end
      rst = 1'b1;
      @(posedge clk); #1;
      probe(637, 335, 1'b0, r);
      n_cmp++; if (r !== BG) begin n_bad++; $display("FAIL abort_o_hidden got %h exp %h", r, BG); end
      probe(601, 335, 1'b0, r);
      n_cmp++; if (r !== FG) begin n_bad++; $display("FAIL abort_l got %h exp %h", r, FG); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_idle_pass();
      test_reveal();
      test_blink();
      test_exit();
      test_switch();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
